// File: rtl/mask_encoder16.sv
// Sequential mask encoder: takes one 16-bit request mask and emits the index of
// each set bit, lowest first, one index per output handshake.
module mask_encoder16 #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mask_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] index_out,
    output logic             out_last,
    output logic [CNT_W-1:0] bit_count,
    output logic             multi_err,
    output logic             empty
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             multi_err_q, multi_err_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] pend_next;
    logic [CNT_W-1:0] in_cnt;

    // Fixed-priority search: the last hit while scanning downward is the lowest set bit.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        index_d     = index_q;
        last_d      = last_q;
        bit_count_d = bit_count_q;
        multi_err_d = multi_err_q;
        empty_d     = 1'b0;
        in_cnt      = popcnt(mask_in);
        pend_next   = pending_q & (pending_q - WIDTH'(1));

        if (state_q == IDLE) begin
            if (in_valid) begin
                pending_d   = mask_in;
                bit_count_d = in_cnt;
                multi_err_d = (in_cnt >= CNT_W'(2));
                if (mask_in == '0) begin
                    empty_d = 1'b1;
                end else begin
                    state_d = EMIT;
                    index_d = lowest_idx(mask_in);
                    last_d  = (in_cnt == CNT_W'(1));
                end
            end
        end else if (out_ready) begin
            pending_d = pend_next;
            if (last_q) begin
                state_d = IDLE;
                last_d  = 1'b0;
            end else begin
                index_d = lowest_idx(pend_next);
                // Exactly one bit left once clearing its lowest bit leaves nothing.
                last_d  = ((pend_next & (pend_next - WIDTH'(1))) == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            index_q     <= '0;
            last_q      <= 1'b0;
            bit_count_q <= '0;
            multi_err_q <= 1'b0;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            index_q     <= index_d;
            last_q      <= last_d;
            bit_count_q <= bit_count_d;
            multi_err_q <= multi_err_d;
            empty_q     <= empty_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign index_out = index_q;
    assign out_last  = last_q;
    assign bit_count = bit_count_q;
    assign multi_err = multi_err_q;
    assign empty     = empty_q;

endmodule

// File: tb/tb_mask_encoder16.sv
// Scoreboard bench for mask_encoder16: driver pushes expected beats, monitor
// pops and compares on every presented index.
module tb_mask_encoder16;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [15:0] mask_in;
    logic        out_valid, out_ready;
    logic [3:0]  index_out;
    logic        out_last;
    logic [4:0]  bit_count;
    logic        multi_err, empty;

    mask_encoder16 dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .mask_in(mask_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .index_out(index_out), .out_last(out_last),
        .bit_count(bit_count), .multi_err(multi_err), .empty(empty)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
        logic [4:0] cnt;
        logic       merr;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    ready_mode = 0;  // 0 random, 1 held high, 2 held low

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the mask bit by bit, one beat per set bit.
    task automatic push_expected(input logic [15:0] m);
        int n;
        int seen;
        beat_t b;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m[i]);
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                seen++;
                b.idx  = 4'(i);
                b.last = (seen == n);
                b.cnt  = 5'(n);
                b.merr = (n >= 2);
                exp_q.push_back(b);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Monitor
    initial begin : monitor
        beat_t b;
        bit    prev_more;
        bit    expect_idle;
        prev_more   = 0;
        expect_idle = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_more   = 0;
                expect_idle = 0;
            end else begin
                if (expect_idle) begin
                    chk("in_ready_after_last", int'(in_ready), 1);
                    chk("valid_after_last", int'(out_valid), 0);
                end
                if (prev_more) chk("no_gap_valid", int'(out_valid), 1);
                prev_more   = 0;
                expect_idle = 0;
                if (out_valid) begin
                    chk("in_ready_in_emit", int'(in_ready), 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        b = exp_q[0];
                        chk("index_out", int'(index_out), int'(b.idx));
                        chk("out_last", int'(out_last), int'(b.last));
                        chk("bit_count", int'(bit_count), int'(b.cnt));
                        chk("multi_err", int'(multi_err), int'(b.merr));
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            if (b.last) expect_idle = 1;
                            else        prev_more   = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] m);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n == 200) chk("timeout_in_ready", 0, 1);
        in_valid = 1'b1;
        mask_in  = m;
        @(posedge clk);
        push_expected(m);
        #1;
        in_valid = 1'b0;
        mask_in  = 16'($urandom);
        @(negedge clk);
        if (m == 16'h0) begin
            chk("empty_pulse", int'(empty), 1);
            chk("zero_no_valid", int'(out_valid), 0);
            chk("zero_bit_count", int'(bit_count), 0);
            chk("zero_multi_err", int'(multi_err), 0);
            chk("zero_in_ready", int'(in_ready), 1);
            @(negedge clk);
            chk("empty_one_cycle", int'(empty), 0);
            chk("zero_no_valid2", int'(out_valid), 0);
        end else begin
            chk("latency_valid", int'(out_valid), 1);
        end
    endtask

    // Junk in_valid pulses during EMIT must be ignored.
    task automatic wait_done();
        int n;
        n = 0;
        forever begin
            @(posedge clk); #1;
            if (in_ready) break;
            in_valid = ($urandom_range(0, 1) == 1);
            mask_in  = 16'($urandom);
            n++;
            if (n >= 300) begin
                chk("timeout_done", 0, 1);
                break;
            end
        end
        in_valid = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic run(input logic [15:0] m);
        send(m);
        if (m != 16'h0) wait_done();
    endtask

    initial begin : driver
        int n;
        logic [15:0] m;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mask_in   = 16'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_index", int'(index_out), 0);
        chk("rst_bit_count", int'(bit_count), 0);
        chk("rst_multi_err", int'(multi_err), 0);
        chk("rst_empty", int'(empty), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);

        ready_mode = 1;
        run(16'h0001);
        run(16'h8421);
        run(16'h0000);
        chk("hold_bit_count_after_zero", int'(bit_count), 0);

        ready_mode = 2;
        send(16'h00C0);
        repeat (3) @(posedge clk);
        ready_mode = 1;
        wait_done();
        chk("hold_bit_count_idle", int'(bit_count), 2);
        chk("hold_multi_err_idle", int'(multi_err), 1);

        run(16'hFFFF);

        ready_mode = 0;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 4))
                0:       m = 16'h0;
                1:       m = 16'(1) << $urandom_range(0, 15);
                2:       m = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: m = 16'($urandom);
            endcase
            run(m);
        end

        // Reset in the middle of an EMIT burst.
        ready_mode = 1;
        send(16'hFFFF);
        n = 0;
        while (!(out_valid && index_out == 4'd5) && n < 100) begin
            @(negedge clk); n++;
        end
        if (n == 100) chk("timeout_index5", 0, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_index", int'(index_out), 0);
        chk("midrst_bit_count", int'(bit_count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        chk("post_rst_multi_err", int'(multi_err), 0);
        run(16'h0300);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mask_encoder16.md
Name: mask_encoder16

Overview:
- Sequential counterpart to the team's 4-to-16 one-hot decoder. This block encodes in the opposite direction: a 16-bit mask becomes 4-bit indices.
- Accepts one 16-bit request mask per transaction. Emits the binary index of every set bit, lowest bit first, one index per output handshake.
- Sits between request-vector producers and consumers that service one indexed request at a time, such as interrupt and channel servicing.

Parameters:
- WIDTH, 16, mask width. Only 16 is supported; the parameter is kept for readability.
- IDX_W, 4, index width; equals log2(WIDTH).
- CNT_W, 5, population-count width; holds 0..16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  mask_in is valid
- in_ready  output  1  block can accept a mask
- mask_in  input  16  request mask
- out_valid  output  1  index_out is valid
- out_ready  input  1  consumer accepts index_out
- index_out  output  4  binary index of the current lowest pending set bit
- out_last  output  1  current index is the final one for this mask
- bit_count  output  5  number of set bits in the most recently accepted mask
- multi_err  output  1  the most recently accepted mask had 2 or more bits set
- empty  output  1  one-cycle pulse: the accepted mask was all zero

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - state=IDLE, pending=0.
  - out_valid=0, index_out=0, out_last=0, bit_count=0, multi_err=0, empty=0.
  - in_ready=1 as soon as reset applies.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
  - in_ready and out_valid are decoded directly from state.
- Accept: in_valid && in_ready at a rising edge. At that edge the block registers:
  - pending=mask_in.
  - bit_count=popcount(mask_in).
  - multi_err=(popcount>=2).
- Non-zero accepted mask:
  - Go to EMIT; index_out=index of lowest set bit; out_last=(popcount==1).
  - out_valid is high in the cycle after the accept edge, so latency is 1 cycle.
- Zero accepted mask:
  - Stay in IDLE; empty=1 for exactly the next cycle, then 0.
  - No out_valid beat is produced; bit_count=0; multi_err=0.
- Output handshake: out_valid && out_ready at an edge.
  - Clear the lowest set bit of pending.
  - If out_last=1: go to IDLE, out_valid=0, in_ready=1 next cycle.
  - Otherwise: index_out=index of next-lowest set bit; out_last=(exactly one bit remains).
- Throughput:
  - One index per cycle while out_ready is held high.
  - One bubble cycle between the final beat of a mask and acceptance of the next mask. There is no same-cycle bypass.
- Backpressure: while out_valid && !out_ready, index_out and out_last hold stable.
- in_valid during EMIT is ignored. mask_in is not sampled until the return to IDLE.
- bit_count and multi_err hold their values until the next accept, including across IDLE.
- Index search is a fixed-priority lowest-bit search over pending, registered; there is no combinational path from mask_in to index_out.
- Popcount is computed on mask_in at accept, zero-extended to 5 bits; 16'hFFFF gives 16.
- Reset asserted mid-EMIT:
  - Remaining indices are discarded.
  - out_valid drops immediately.
  - On release the block is in IDLE with all outputs at reset values.

Test Plan:
- Reset: hold rst_n low, then release -> in_ready=1, out_valid=0, index_out=0, bit_count=0, multi_err=0, empty=0.
- mask_in=16'h0001 with out_ready=1 -> one beat: index_out=0, out_last=1, bit_count=1, multi_err=0; in_ready=1 the cycle after the beat.
- mask_in=16'h8421 with out_ready=1 -> indices 0,5,10,15 on 4 consecutive cycles; out_last=1 only on 15; bit_count=4; multi_err=1; in_valid pulsed during EMIT is ignored.
- mask_in=16'h0000 -> empty high for exactly one cycle; out_valid never rises; bit_count=0; in_ready stays 1.
- mask_in=16'h00C0, out_ready low for 3 cycles -> index_out=6 and out_last=0 held stable; then raise out_ready -> indices 6 then 7 with out_last=1.
- mask_in=16'hFFFF -> bit_count=16 and indices 0..15 in order; a second run asserts rst_n after the beat with index 5 -> out_valid=0 immediately and in_ready=1 after release.
